regfile: RTL and testbench

//  - 32 x 32-bit general-purpose register file; answers the decode stage's two register read requests.
//  - Decode drives re1/raddr1 and re2/raddr2 and consumes rdata1/rdata2 in the same cycle.
//  - Writeback drives the single write port.
//  - x0 is hardwired to zero.
//  - Sits between the writeback path and stage_id in the 5-stage pipeline.

---
 rtl/regfile_if.sv | 26 ++
 rtl/regfile.sv | 62 ++++++
 tb/tb_regfile.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_if.sv
// Register-file ports shared by decode (two reads) and writeback (one write).
// master = pipeline side driving requests; slave = regfile returning read data.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// 32x32 register file, x0 hardwired to zero; two combinational read ports, one write port.
// Latency 0 on reads; optional write-through bypass on reads enabled by REGFILE_BYPASS_EN.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en_d;

  assign wr_en_d = bus.we && (bus.waddr != '0);

  // Entry 0 is only ever written by reset, so it reads as zero forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] rd;
    rd = stored;
    if (!rst_v || !re || (raddr == '0)) begin
      rd = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (waddr == raddr)) begin
      rd = wdata;
    end
`endif
    return rd;
  endfunction

  // Without bypass the write-port inputs are still passed in so both builds share one mux shape.
  always_comb begin
    bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, regs_q[bus.raddr1],
                           wr_en_d, bus.waddr, bus.wdata);
  end

  always_comb begin
    bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, regs_q[bus.raddr2],
                           wr_en_d, bus.waddr, bus.wdata);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by randomized traffic
// compared against an array-based model of the register file.
module tb_regfile;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [31:0] model [32];

  regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value derived from the architectural register contents.
  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (!rst || !re || ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.waddr == ra) return bus.wdata;
`endif
    return model[ra];
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, "_p1"}, bus.rdata1, exp_rd(bus.re1, bus.raddr1));
    chk({tag, "_p2"}, bus.rdata2, exp_rd(bus.re2, bus.raddr2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst && bus.we && bus.waddr != 5'd0) model[bus.waddr] = bus.wdata;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2);
    bus.raddr1 = a1; bus.re1 = e1; bus.raddr2 = a2; bus.re2 = e2;
    #1;
  endtask

  initial begin
    logic [31:0] v;
    tests = 0;
    fails = 0;
    clear_model();
    rst = 1'b0;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5; bus.re2 = 1'b1; bus.raddr2 = 5'd31;
    #1;
    chk("reset_rd1", bus.rdata1, 32'h0);
    chk("reset_rd2", bus.rdata2, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Post-reset contents are all zero.
    for (int i = 1; i < 32; i += 6) begin
      rd(5'(i), 1'b1, 5'(31 - i), 1'b1);
      chk("post_reset_p1", bus.rdata1, 32'h0);
      chk("post_reset_p2", bus.rdata2, 32'h0);
    end

    // Reset clears a written entry without any clock edge.
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 1'b1, 5'd0, 1'b0);
    chk("x5_written", bus.rdata1, 32'hDEADBEEF);
    #1 rst = 1'b0; clear_model();
    #1;
    chk("x5_during_rst", bus.rdata1, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("x5_after_rst", bus.rdata1, 32'h0);
    @(negedge clk);

    // x0 never changes.
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
    rd(5'd0, 1'b1, 5'd0, 1'b1);
    chk("x0_same_cycle", bus.rdata1, 32'h0);
    tick();
    bus.we = 1'b0;
    rd(5'd0, 1'b1, 5'd0, 1'b1);
    chk("x0_after_p1", bus.rdata1, 32'h0);
    chk("x0_after_p2", bus.rdata2, 32'h0);

    // Dual read and read-enable gating.
    wr(5'd1, 32'h11111111);
    wr(5'd2, 32'h22222222);
    rd(5'd1, 1'b1, 5'd2, 1'b1);
    chk("dual_p1", bus.rdata1, 32'h11111111);
    chk("dual_p2", bus.rdata2, 32'h22222222);
    rd(5'd1, 1'b1, 5'd2, 1'b0);
    chk("dual_re2_off", bus.rdata2, 32'h0);
    rd(5'd2, 1'b1, 5'd2, 1'b1);
    chk("same_idx_p1", bus.rdata1, 32'h22222222);
    chk("same_idx_p2", bus.rdata2, 32'h22222222);

    // Same-cycle read/write of one index.
    wr(5'd7, 32'hA);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hB;
    rd(5'd7, 1'b1, 5'd7, 1'b1);
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_cycle", bus.rdata1, 32'hB);
`else
    chk("rw_same_cycle", bus.rdata1, 32'hA);
`endif
    tick();
    bus.we = 1'b0;
    #1;
    chk("rw_next_cycle", bus.rdata1, 32'hB);

    // Back-to-back writes: last one wins.
    wr(5'd9, 32'h12345678);
    wr(5'd9, 32'h0000FFFF);
    rd(5'd9, 1'b1, 5'd9, 1'b1);
    chk("b2b_last_wins", bus.rdata1, 32'h0000FFFF);

    // Write presented while reset is held across a posedge is lost.
    wr(5'd3, 32'h77);
    rst = 1'b0; clear_model();
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h55;
    tick();
    rst = 1'b1;
    bus.we = 1'b0;
    rd(5'd3, 1'b1, 5'd3, 1'b1);
    chk("wr_during_rst", bus.rdata1, 32'h0);

    // First write after release lands on the first rising edge.
    wr(5'd3, 32'h66);
    rd(5'd3, 1'b1, 5'd3, 1'b1);
    chk("first_wr_after_rst", bus.rdata1, 32'h66);

    // Sweep every register through both ports.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 1; i < 32; i++) begin
      v = 32'(i) * 32'h01010101;
      rd(5'(i), 1'b1, 5'(i), 1'b1);
      chk($sformatf("sweep_p1_x%0d", i), bus.rdata1, v);
      chk($sformatf("sweep_p2_x%0d", i), bus.rdata2, v);
    end

    // Randomized traffic against the model, with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      if (!rst) clear_model();
      bus.we = ($urandom_range(0, 3) != 0);
      bus.waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.wdata = $urandom;
      bus.re1 = ($urandom_range(0, 7) != 0);
      bus.re2 = ($urandom_range(0, 7) != 0);
      bus.raddr1 = ($urandom_range(0, 2) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 31));
      #1;
      chk_model("rand");
      tick();
    end
    rst = 1'b1;
    bus.we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
